// File: rtl/fc_vec_collector.sv
// fc_vec_collector: assembles a byte-serial activation stream into
// IN-element vectors using a two-bank ping-pong buffer.
//
// Ports:
//   clk, rst_n  - rising-edge clock, synchronous active-low reset
//   in_data     - activation element, index = arrival order in frame
//   in_valid    - in_data valid
//   in_last     - final element of a frame
//   in_ready    - collector accepts a beat this cycle
//   x           - assembled vector, x[0] = first beat of frame
//   vec_valid   - x holds a complete frame
//   vec_ready   - consumer has taken x
//   err_len     - one-cycle pulse on a frame-length error
//   wr_idx      - element index currently being filled
module fc_vec_collector #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    localparam int CW   = $clog2(IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic             err_len,
    output logic [CW-1:0]    wr_idx
);

    localparam logic [CW-1:0] LAST_IDX = CW'(IN - 1);

    logic [WIDTH-1:0] bank [0:1][0:IN-1];
    logic [1:0]       full;
    logic             wr_sel;
    logic             rd_sel;
    logic [CW-1:0]    wr_cnt;

    logic accept;
    logic release_vec;

    assign in_ready    = !full[wr_sel];
    assign vec_valid   = full[rd_sel];
    assign wr_idx      = wr_cnt;
    assign accept      = in_valid && in_ready;
    assign release_vec = vec_valid && vec_ready;

    always_comb begin
        for (int i = 0; i < IN; i++) begin
            x[i] = bank[rd_sel][i];
        end
    end

    // The write bank is never full when set and the read bank is always
    // full when cleared, so the two flag updates below never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < IN; i++) begin
                    bank[b][i] <= '0;
                end
            end
            full    <= 2'b00;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            wr_cnt  <= '0;
            err_len <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (accept) begin
                bank[wr_sel][wr_cnt] <= in_data;
                if (wr_cnt == LAST_IDX) begin
                    // Full-length frame is committed even without in_last.
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= !wr_sel;
                    wr_cnt       <= '0;
                    err_len      <= !in_last;
                end else if (in_last) begin
                    // Short frame: drop it and refill the same bank.
                    wr_cnt  <= '0;
                    err_len <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + CW'(1);
                end
            end
            if (release_vec) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_fc_vec_collector.sv
// tb_fc_vec_collector: directed bench with a scoreboard of expected
// vectors popped on every output handshake.
module tb_fc_vec_collector;

    localparam int W  = 8;
    localparam int N  = 128;
    localparam int VB = W * N;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] x [0:N-1];
    logic         vec_valid;
    logic         vec_ready;
    logic         err_len;
    logic [6:0]   wr_idx;

    logic [VB-1:0] xp;
    logic [VB-1:0] exp_q [$];

    int ncmp = 0;
    int nerr = 0;
    int n_err_pulse = 0;
    int n_hs = 0;
    int stalls = 0;

    fc_vec_collector #(.WIDTH(W), .IN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .x         (x),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .err_len   (err_len),
        .wr_idx    (wr_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            xp[i*W +: W] = x[i];
        end
    end

    task automatic check(input string tag, input logic [VB-1:0] obs,
                         input logic [VB-1:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Output monitor: every handshake must match the oldest expected vector.
    always @(negedge clk) begin
        if (rst_n && err_len) n_err_pulse++;
        if (rst_n && vec_valid && vec_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                check("unexpected_vec", 1, 0);
            end else begin
                check("vec_data", xp, exp_q.pop_front());
            end
        end
    end

    function automatic logic [VB-1:0] mk_frame(input int base);
        logic [VB-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'((base + i) % 256);
        return v;
    endfunction

    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        t = 0;
        while (!in_ready && t < 400) begin
            stalls++;
            @(posedge clk); #1;
            t++;
        end
        if (t >= 400) check("beat_timeout", {{(VB-1){1'b0}}, in_ready}, 1);
        @(posedge clk); #1;
    endtask

    // Sends n beats of v; last_at < 0 means in_last is never raised.
    task automatic send_frame(input logic [VB-1:0] v, input int n,
                              input int last_at);
        for (int i = 0; i < n; i++) begin
            send_beat(v[i*W +: W], i == last_at);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        vec_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
        check("drain_vvalid", vec_valid, 0);
    endtask

    logic [VB-1:0] f0, f1, f2, fh;
    int e0;
    logic stable;

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        vec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_in_ready", in_ready, 1);
        check("rst_vec_valid", vec_valid, 0);
        check("rst_err_len", err_len, 0);
        check("rst_wr_idx", wr_idx, 0);
        check("rst_x", xp, 0);

        // Single frame, held for 20 cycles under backpressure.
        f0 = mk_frame(0);
        exp_q.push_back(f0);
        send_frame(f0, N, N - 1);
        check("t1_vvalid_latency", vec_valid, 1);
        check("t1_in_ready", in_ready, 1);
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (xp !== f0 || !vec_valid) stable = 1'b0;
        end
        check("t1_x_stable", stable, 1);
        check("t1_no_err", n_err_pulse, 0);
        drain();
        vec_ready = 1'b0;

        // Back-to-back streaming with the consumer keeping pace.
        vec_ready = 1'b1;
        stalls = 0;
        e0 = n_hs;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk_frame(k * 16));
            send_frame(mk_frame(k * 16), N, N - 1);
        end
        drain();
        check("t2_no_stall", stalls, 0);
        check("t2_hs_count", n_hs - e0, 4);
        vec_ready = 1'b0;

        // Backpressure: two banks fill, third frame waits.
        f0 = mk_frame(100);
        f1 = mk_frame(150);
        f2 = mk_frame(200);
        exp_q.push_back(f0);
        exp_q.push_back(f1);
        exp_q.push_back(f2);
        send_frame(f0, N, N - 1);
        send_frame(f1, N, N - 1);
        check("t3_ready_low", in_ready, 0);
        in_valid = 1'b1;
        in_data  = f2[W-1:0];
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("t3_still_low", in_ready, 0);
        check("t3_wr_idx_hold", wr_idx, 0);
        vec_ready = 1'b1;
        @(posedge clk); #1;
        vec_ready = 1'b0;
        check("t3_ready_back", in_ready, 1);
        check("t3_one_left", exp_q.size(), 2);
        send_frame(f2, N, N - 1);
        check("t3_ready_low2", in_ready, 0);
        drain();
        vec_ready = 1'b0;

        // Early last on beat 49.
        e0 = n_err_pulse;
        send_frame(mk_frame(7), 50, 49);
        check("t4_err_pulse", err_len, 1);
        check("t4_no_vvalid", vec_valid, 0);
        check("t4_wr_idx", wr_idx, 0);
        @(posedge clk); #1;
        check("t4_err_clear", err_len, 0);
        check("t4_err_count", n_err_pulse - e0, 1);
        fh = mk_frame(33);
        exp_q.push_back(fh);
        send_frame(fh, N, N - 1);
        check("t4_next_vvalid", vec_valid, 1);
        drain();
        vec_ready = 1'b0;

        // Missing last: committed anyway with an error pulse.
        e0 = n_err_pulse;
        fh = mk_frame(77);
        exp_q.push_back(fh);
        send_frame(fh, N, -1);
        check("t5_err_pulse", err_len, 1);
        check("t5_vvalid", vec_valid, 1);
        @(posedge clk); #1;
        check("t5_err_count", n_err_pulse - e0, 1);
        drain();
        vec_ready = 1'b0;

        // Reset mid-frame with the other bank full.
        send_frame(mk_frame(5), N, N - 1);
        send_frame(mk_frame(9), 60, -1);
        check("t6_pre_idx", wr_idx, 60);
        check("t6_pre_vvalid", vec_valid, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t6_vvalid", vec_valid, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_wr_idx", wr_idx, 0);
        check("t6_x_zero", xp, 0);
        fh = mk_frame(211);
        exp_q.push_back(fh);
        send_frame(fh, N, N - 1);
        drain();
        vec_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
